// File: rtl/f8_dmem_port.sv
// F8 data-memory access stage: steers byte/word loads and stores onto the
// even/odd RAM banks and returns big-endian responses under back-pressure.

// One RAM bank lane: held addresses, one-deep store forward, merged read byte.
module f8_dmem_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd,
  input  logic        wsel,
  input  logic        we,
  input  logic [14:0] addr,
  input  logic [7:0]  wbyte,
  input  logic [7:0]  rbyte_in,
  output logic [14:0] rd_addr,
  output logic [14:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  rbyte
);
  logic [14:0] rd_q, wr_q, fwd_addr;
  logic [7:0]  wd_q, fwd_data, hit_data;
  logic        fwd_vld, hit_q;

  assign rd_addr = rd   ? addr  : rd_q;
  assign wr_addr = wsel ? addr  : wr_q;
  assign wr_data = wsel ? wbyte : wd_q;
  assign rbyte   = hit_q ? hit_data : rbyte_in;

  // The bank returns old data on read-during-write, so a load issued the
  // cycle after a store to the same bank word takes the store's byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      wr_q     <= '0;
      wd_q     <= '0;
      fwd_vld  <= 1'b0;
      fwd_addr <= '0;
      fwd_data <= '0;
      hit_q    <= 1'b0;
      hit_data <= '0;
    end else begin
      rd_q     <= rd_addr;
      wr_q     <= wr_addr;
      wd_q     <= wr_data;
      fwd_vld  <= we;
      fwd_addr <= wr_addr;
      fwd_data <= wr_data;
      hit_q    <= rd && fwd_vld && (fwd_addr == addr);
      hit_data <= fwd_data;
    end
  end
endmodule

module f8_dmem_port #(
  parameter int ADDRBITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [14:0] dread_addr_even,
  output logic [14:0] dread_addr_odd,
  input  logic [7:0]  dread_data_even,
  input  logic [7:0]  dread_data_odd,
  output logic [14:0] dwrite_addr_even,
  output logic [14:0] dwrite_addr_odd,
  output logic [7:0]  dwrite_data_even,
  output logic [7:0]  dwrite_data_odd,
  output logic        dwrite_en_even,
  output logic        dwrite_en_odd
);
  localparam int NUM_LANES = 2;
  localparam int RAMBASE_I = 32'h4000 - (1 << ADDRBITS);
  localparam logic [15:0] RAMBASE = RAMBASE_I[15:0];

  function automatic logic in_win(input logic [15:0] x);
    return (x >= RAMBASE) && (x <= 16'h3fff);
  endfunction

  logic        fire, odd, ok_hi, ok_lo, err;
  logic [15:0] a_lo;
  logic [7:0]  hi_b, lo_b;
  logic [NUM_LANES-1:0]       lane_use, lane_rd, lane_wsel, lane_we;
  logic [NUM_LANES-1:0][14:0] lane_addr, lane_raddr, lane_waddr;
  logic [NUM_LANES-1:0][7:0]  lane_wbyte, lane_wdata, lane_rdin, lane_rbyte;

  logic        ready_en;
  logic        p_vld, p_write, p_word, p_odd, p_ok_hi, p_ok_lo, p_err;
  logic [7:0]  p_hi, p_lo;
  logic [15:0] p_rdata;
  logic        h_vld, h_err;
  logic [15:0] h_rdata;

  assign fire  = req_valid && req_ready;
  assign odd   = req_addr[0];
  assign a_lo  = req_addr + 16'd1;
  assign ok_hi = in_win(req_addr);
  assign ok_lo = !req_word || in_win(a_lo);
  assign err   = !(ok_hi && ok_lo);

  // Lane 0 = even bank, lane 1 = odd bank. A word at even A shares one bank
  // index across both lanes; at odd A the even lane moves to (A+1)>>1.
  assign hi_b          = req_word ? req_wdata[15:8] : req_wdata[7:0];
  assign lo_b          = req_wdata[7:0];
  assign lane_use[0]   = !odd || req_word;
  assign lane_use[1]   = odd || req_word;
  assign lane_addr[0]  = odd ? a_lo[15:1] : req_addr[15:1];
  assign lane_addr[1]  = req_addr[15:1];
  assign lane_wbyte[0] = odd ? lo_b : hi_b;
  assign lane_wbyte[1] = odd ? hi_b : lo_b;
  assign lane_rdin[0]  = dread_data_even;
  assign lane_rdin[1]  = dread_data_odd;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_rd[i]   = fire && !req_write && lane_use[i];
    assign lane_wsel[i] = fire && req_write && lane_use[i];
    assign lane_we[i]   = lane_wsel[i] && !err;
    f8_dmem_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd       (lane_rd[i]),
      .wsel     (lane_wsel[i]),
      .we       (lane_we[i]),
      .addr     (lane_addr[i]),
      .wbyte    (lane_wbyte[i]),
      .rbyte_in (lane_rdin[i]),
      .rd_addr  (lane_raddr[i]),
      .wr_addr  (lane_waddr[i]),
      .wr_data  (lane_wdata[i]),
      .rbyte    (lane_rbyte[i])
    );
  end

  assign dread_addr_even  = lane_raddr[0];
  assign dread_addr_odd   = lane_raddr[1];
  assign dwrite_addr_even = lane_waddr[0];
  assign dwrite_addr_odd  = lane_waddr[1];
  assign dwrite_data_even = lane_wdata[0];
  assign dwrite_data_odd  = lane_wdata[1];
  assign dwrite_en_even   = lane_we[0];
  assign dwrite_en_odd    = lane_we[1];

  // Realign bank bytes; out-of-window bytes read as 0xff.
  assign p_hi    = !p_ok_hi ? 8'hff : (p_odd ? lane_rbyte[1] : lane_rbyte[0]);
  assign p_lo    = !p_ok_lo ? 8'hff : (p_odd ? lane_rbyte[0] : lane_rbyte[1]);
  assign p_rdata = p_write ? 16'h0000 : (p_word ? {p_hi, p_lo} : {8'h00, p_hi});

  // Hold and live stage are never valid together: a stall blocks new issue.
  assign rsp_valid = h_vld || p_vld;
  assign rsp_rdata = h_vld ? h_rdata : (p_vld ? p_rdata : 16'h0000);
  assign rsp_err   = h_vld ? h_err : (p_vld && p_err);
  assign req_ready = ready_en && !(rsp_valid && !rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      p_vld    <= 1'b0;
      p_write  <= 1'b0;
      p_word   <= 1'b0;
      p_odd    <= 1'b0;
      p_ok_hi  <= 1'b0;
      p_ok_lo  <= 1'b0;
      p_err    <= 1'b0;
      h_vld    <= 1'b0;
      h_err    <= 1'b0;
      h_rdata  <= '0;
    end else begin
      ready_en <= 1'b1;
      p_vld    <= fire;
      if (fire) begin
        p_write <= req_write;
        p_word  <= req_word;
        p_odd   <= odd;
        p_ok_hi <= ok_hi;
        p_ok_lo <= ok_lo;
        p_err   <= err;
      end
      if (p_vld && !rsp_ready) begin
        h_vld   <= 1'b1;
        h_rdata <= p_rdata;
        h_err   <= p_err;
      end else if (h_vld && rsp_ready) begin
        h_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_f8_dmem_port.sv
// Directed bench for f8_dmem_port with a banked RAM model whose writes land
// one cycle late, so reads-during-write see old data.
module tb_f8_dmem_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write, req_word;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [14:0] dread_addr_even, dread_addr_odd, dwrite_addr_even, dwrite_addr_odd;
  logic [7:0]  dread_data_even, dread_data_odd, dwrite_data_even, dwrite_data_odd;
  logic        dwrite_en_even, dwrite_en_odd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  f8_dmem_port #(.ADDRBITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dread_addr_even(dread_addr_even), .dread_addr_odd(dread_addr_odd),
    .dread_data_even(dread_data_even), .dread_data_odd(dread_data_odd),
    .dwrite_addr_even(dwrite_addr_even), .dwrite_addr_odd(dwrite_addr_odd),
    .dwrite_data_even(dwrite_data_even), .dwrite_data_odd(dwrite_data_odd),
    .dwrite_en_even(dwrite_en_even), .dwrite_en_odd(dwrite_en_odd)
  );

  // RAM model: registered read, write committed one edge after it is presented
  logic [7:0]  mem_e [0:32767];
  logic [7:0]  mem_o [0:32767];
  logic        pw_e = 1'b0, pw_o = 1'b0;
  logic [14:0] pa_e, pa_o;
  logic [7:0]  pd_e, pd_o;

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem_e[i] = 8'h00;
      mem_o[i] = 8'h00;
    end
  end

  always @(posedge clk) begin
    dread_data_even <= mem_e[dread_addr_even];
    dread_data_odd  <= mem_o[dread_addr_odd];
    if (pw_e) mem_e[pa_e] <= pd_e;
    if (pw_o) mem_o[pa_o] <= pd_o;
    pw_e <= dwrite_en_even;
    pa_e <= dwrite_addr_even;
    pd_e <= dwrite_data_even;
    pw_o <= dwrite_en_odd;
    pa_o <= dwrite_addr_odd;
    pd_o <= dwrite_data_odd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_we;
  } vec_t;

  localparam int NV = 19;
  vec_t v [NV];

  typedef struct {
    logic        word;
    logic [15:0] addr;
    logic [15:0] exp_rd;
  } bp_t;
  bp_t bp [3];

  int idx, got, cyc, seen;

  initial begin
    v[0]  = '{1'b1, 1'b1, 16'h3c00, 16'h1234, 16'h0000, 1'b0, 2};
    v[1]  = '{1'b0, 1'b1, 16'h3c00, 16'h0000, 16'h1234, 1'b0, 0};
    v[2]  = '{1'b1, 1'b0, 16'h3c05, 16'h00ab, 16'h0000, 1'b0, 1};
    v[3]  = '{1'b0, 1'b0, 16'h3c05, 16'h0000, 16'h00ab, 1'b0, 0};
    v[4]  = '{1'b0, 1'b1, 16'h3c04, 16'h0000, 16'h00ab, 1'b0, 0};
    v[5]  = '{1'b1, 1'b1, 16'h3c07, 16'hbeef, 16'h0000, 1'b0, 2};
    v[6]  = '{1'b0, 1'b1, 16'h3c07, 16'h0000, 16'hbeef, 1'b0, 0};
    v[7]  = '{1'b1, 1'b0, 16'h3fff, 16'h009c, 16'h0000, 1'b0, 1};
    v[8]  = '{1'b1, 1'b0, 16'h3bff, 16'h0077, 16'h0000, 1'b1, 0};
    v[9]  = '{1'b1, 1'b1, 16'h3fff, 16'h5555, 16'h0000, 1'b1, 0};
    v[10] = '{1'b0, 1'b0, 16'h4000, 16'h0000, 16'h00ff, 1'b1, 0};
    v[11] = '{1'b0, 1'b1, 16'h3fff, 16'h0000, 16'h9cff, 1'b1, 0};
    v[12] = '{1'b0, 1'b1, 16'h3c00, 16'h0000, 16'h1234, 1'b0, 0};
    v[13] = '{1'b0, 1'b1, 16'h3c06, 16'h0000, 16'h00be, 1'b0, 0};
    v[14] = '{1'b0, 1'b0, 16'h3c08, 16'h0000, 16'h00ef, 1'b0, 0};
    v[15] = '{1'b1, 1'b1, 16'h3c05, 16'ha1b2, 16'h0000, 1'b0, 2};
    v[16] = '{1'b0, 1'b0, 16'h3c06, 16'h0000, 16'h00b2, 1'b0, 0};
    v[17] = '{1'b1, 1'b0, 16'h3c10, 16'h00cd, 16'h0000, 1'b0, 1};
    v[18] = '{1'b0, 1'b1, 16'h3c10, 16'h0000, 16'hcd00, 1'b0, 0};
    bp[0] = '{1'b1, 16'h3c00, 16'h1234};
    bp[1] = '{1'b0, 16'h3c05, 16'h00a1};
    bp[2] = '{1'b1, 16'h3c07, 16'hbeef};

    req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Reset state
    #12;
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    chk("reset dwrite_en", 32'({dwrite_en_even, dwrite_en_odd}), 0);
    chk("reset addrs", 32'(dread_addr_even | dread_addr_odd | dwrite_addr_even | dwrite_addr_odd), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready after release", 32'(req_ready), 1);

    // Back-to-back table; each response is checked the cycle after issue
    for (int i = 0; i <= NV; i++) begin
      @(posedge clk); #1;
      if (i < NV) begin
        req_valid = 1'b1; req_write = v[i].wr; req_word = v[i].word;
        req_addr = v[i].addr; req_wdata = v[i].wdata;
      end else begin
        req_valid = 1'b0;
      end
      #3;
      if (i < NV) begin
        chk($sformatf("v%0d req_ready", i), 32'(req_ready), 1);
        chk($sformatf("v%0d write strobes", i), 32'(int'(dwrite_en_even) + int'(dwrite_en_odd)), 32'(v[i].exp_we));
      end
      if (i > 0) begin
        chk($sformatf("v%0d rsp_valid", i-1), 32'(rsp_valid), 1);
        chk($sformatf("v%0d rsp_rdata", i-1), 32'(rsp_rdata), 32'(v[i-1].exp_rd));
        chk($sformatf("v%0d rsp_err", i-1), 32'(rsp_err), 32'(v[i-1].exp_err));
      end
    end

    chk("even bank @3c00", 32'(mem_e[15'h1e00]), 32'h12);
    chk("odd bank @3c01", 32'(mem_o[15'h1e00]), 32'h34);
    chk("odd bank @3c07", 32'(mem_o[15'h1e03]), 32'hbe);
    chk("even bank @3c08", 32'(mem_e[15'h1e04]), 32'hef);
    chk("odd bank @3fff", 32'(mem_o[15'h1fff]), 32'h9c);
    chk("odd bank @3bff untouched", 32'(mem_o[15'h1dff]), 32'h00);

    // Back-pressure: three loads, rsp_ready low for the first stall cycles
    idx = 0; got = 0; cyc = 0;
    while (got < 3 && cyc < 40) begin
      @(posedge clk); #1;
      req_valid = (idx < 3);
      req_write = 1'b0;
      if (idx < 3) begin
        req_word = bp[idx].word; req_addr = bp[idx].addr;
      end
      rsp_ready = (cyc >= 5);
      #3;
      if (cyc >= 1 && cyc <= 4) begin
        chk($sformatf("stall c%0d req_ready", cyc), 32'(req_ready), 0);
        chk($sformatf("stall c%0d held valid", cyc), 32'(rsp_valid), 1);
        chk($sformatf("stall c%0d held rdata", cyc), 32'(rsp_rdata), 32'h1234);
      end
      if (rsp_valid && rsp_ready) begin
        chk($sformatf("bp rsp%0d rdata", got), 32'(rsp_rdata), 32'(bp[got].exp_rd));
        chk($sformatf("bp rsp%0d err", got), 32'(rsp_err), 0);
        got++;
      end
      if (req_valid && req_ready) idx++;
      cyc++;
    end
    chk("bp responses delivered", 32'(got), 3);

    // Reset with requests in flight
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 1'b1; req_word = 1'b1; req_addr = 16'h3c00;
    @(posedge clk); #1;
    req_word = 1'b0; req_addr = 16'h3c08;
    #2;
    chk("inflight rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midreset rsp_valid", 32'(rsp_valid), 0);
    chk("midreset rsp_rdata", 32'(rsp_rdata), 0);
    chk("midreset rsp_err", 32'(rsp_err), 0);
    chk("midreset req_ready", 32'(req_ready), 0);
    chk("midreset dwrite_en", 32'({dwrite_en_even, dwrite_en_odd}), 0);
    chk("midreset addrs", 32'(dread_addr_even | dread_addr_odd | dwrite_addr_even | dwrite_addr_odd), 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #4;
      if (rsp_valid) seen++;
    end
    chk("no response after reset", 32'(seen), 0);
    chk("req_ready after second release", 32'(req_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
